rl_decode_block: RTL and testbench
==================================

// Module: rl_decode_block
// PURPOSE
//  Run-length decoder + inverse zigzag: the receive-side counterpart of the compressor's zigzag/RLE back end.
//  Accepts 15-bit {run,value} symbols, rebuilds one 8x8 block of quantized coefficients in a local buffer,
//  then streams the block out in raster order (addr 0..63) toward the dequantizer / inverse DCT.
// PARAMETERS
//  DW   8   coefficient width (signed, two's complement)
//  RW   7   run field width; symbol width = RW+DW = 15
//  N    64  coefficients per block (8x8)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  in_valid   in   1   symbol valid
//  in_ready   out  1   decoder can accept a symbol
//  in_data    in   15  [14:8] run = zeros preceding value; [7:0] value; {0,0} = EOB
//  out_valid  out  1   raster coefficient valid
//  out_ready  in   1   downstream accepts coefficient
//  out_addr   out  6   raster index row*8+col of out_data
//  out_data   out  8   coefficient value
//  block_done out  1   one-cycle pulse on the cycle the 64th coefficient handshakes
//  err        out  1   one-cycle pulse: malformed symbol dropped
// BEHAVIOUR
//  Reset (rst=0, async): state=FILL, pos=0, buffer all zero, in_ready=1, out_valid=0, out_addr=0,
//   out_data=0, block_done=0, err=0. Reset mid-block discards the partial block; no output resumes.
//  Handshake: transfer when valid&&ready on a rising edge; data held stable while valid&&!ready.
//  FILL (in_ready=1, out_valid=0):
//   - EOB accepted: no write; next state DRAIN (remaining positions already zero). EOB at pos=0 = all-zero block.
//   - Data symbol: tgt = pos+run (8-bit compare). If tgt<=63: buf[ZZ2R[tgt]] <= value; pos <= tgt+1.
//     If tgt+1==64: next state DRAIN; no EOB is expected and none is consumed for that block.
//   - tgt>63 (incl. run>63): symbol dropped, err pulses next cycle, next state DRAIN (block emitted as-is).
//   - A data symbol with value 0 is legal only with run>0 (ZRL-style); written as zero, pos advances.
//  DRAIN (in_ready=0, out_valid=1): out_addr=rd (0..63), out_data=buf[rd], both registered/stable.
//   - rd increments on each out handshake; on rd==63 handshake: block_done pulses same cycle,
//     buffer cleared to zero, pos=0, rd=0, next state FILL (in_ready=1 next cycle).
//  Latency: symbol completing a block accepted at cycle t -> out_valid=1 at t+1; 64 coeffs need >=64 cycles.
//  Throughput: one symbol per cycle in FILL; one coefficient per cycle in DRAIN. No fill/drain overlap.
//  No simultaneous in/out handshakes possible (in_ready and out_valid mutually exclusive).
//  States: FILL, DRAIN (2-state FSM, encoded in package enum).
// STRUCTURE
//  Package rld_pkg: DW/RW/N defaults, typedef enum logic {FILL,DRAIN} rld_state_t,
//   typedef logic signed [DW-1:0] coef_t, EOB constant 15'h0, ZZ2R[0:63] zigzag->raster table.
//  Sub-module zz_to_raster: combinational 6-bit zigzag index -> 6-bit raster index (reads ZZ2R).
//  Buffer: 64 x DW register array (whole-array clear needed; no RAM macro).
// TESTING
//  1 Reset: hold rst=0 -> in_ready=1, out_valid=0, block_done=0, err=0; release, send EOB -> 64 zeros, addr 0..63.
//  2 Symbols (0,5),(2,-3),EOB -> addr0=8'h05, addr16=8'hFD, all other 62 addrs 0; block_done on addr63 handshake.
//  3 64 symbols run=0, value=zz index+1, no EOB -> raster out matches ZZ2R inverse; FILL resumes, next EOB -> zeros.
//  4 pos=60 then symbol (10,7) -> err pulse, symbol dropped, block drained with first 60 zz positions intact.
//  5 Backpressure: out_ready toggled 1-of-3 in DRAIN -> out_addr/out_data stable while stalled, no skips/duplicates.
//  6 Assert rst=0 mid-DRAIN at rd=30 -> out_valid=0 immediately; after release, EOB -> full all-zero block.

Source files
------------

// File: rtl/rld_pkg.sv
// Shared types and constants for the run-length decoder / inverse zigzag block.
package rld_pkg;

  localparam int DW = 8;
  localparam int RW = 7;
  localparam int N  = 64;
  localparam int SW = RW + DW;

  typedef enum logic {FILL, DRAIN} rld_state_t;

  typedef logic signed [DW-1:0] coef_t;

  localparam logic [SW-1:0] EOB = 15'h0;

  // Zigzag scan position -> raster index (row*8+col).
  localparam logic [5:0] ZZ2R [0:N-1] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/zz_to_raster.sv
// Combinational zigzag-index to raster-index lookup.
module zz_to_raster
  import rld_pkg::*;
(
  input  logic [5:0] zz_i,
  output logic [5:0] raster_o
);

  assign raster_o = ZZ2R[zz_i];

endmodule

// File: rtl/rl_decode_block.sv
// Rebuilds one 8x8 block from {run,value} symbols, then streams it out in raster order.
module rl_decode_block
  import rld_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [5:0]    out_addr,
  output logic [DW-1:0] out_data,
  output logic          block_done,
  output logic          err
);

  rld_state_t state_q;
  logic [6:0] pos_q;
  logic [5:0] rd_q;
  logic       err_q;
  coef_t      coef_q [N];

  logic [RW-1:0] run;
  coef_t         value;
  logic [7:0]    tgt;
  logic [5:0]    wr_raster;

  assign run   = in_data[SW-1:DW];
  assign value = coef_t'(in_data[DW-1:0]);
  // Eight bits so that a run past the end of the block is seen as overflow, not wrap.
  assign tgt   = {1'b0, pos_q} + {1'b0, run};

  zz_to_raster u_zz_to_raster (
    .zz_i     (tgt[5:0]),
    .raster_o (wr_raster)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      pos_q   <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      // NOTE: the coefficient buffer is flops, not RAM, so it can be cleared in one cycle here and at block end.
      for (int i = 0; i < N; i++) coef_q[i] <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (in_valid) begin
            if (in_data == EOB) begin
              state_q <= DRAIN;
            end else if (tgt > 8'd63) begin
              err_q   <= 1'b1;
              state_q <= DRAIN;
            end else begin
              coef_q[wr_raster] <= value;
              pos_q             <= tgt[6:0] + 7'd1;
              if (tgt == 8'd63) state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_q == 6'd63) begin
              for (int i = 0; i < N; i++) coef_q[i] <= '0;
              pos_q   <= '0;
              rd_q    <= '0;
              state_q <= FILL;
            end else begin
              rd_q <= rd_q + 6'd1;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign in_ready   = (state_q == FILL);
  assign out_valid  = (state_q == DRAIN);
  assign out_addr   = rd_q;
  assign out_data   = (state_q == DRAIN) ? coef_q[rd_q] : '0;
  assign block_done = out_valid && out_ready && (rd_q == 6'd63);
  assign err        = err_q;

endmodule

// File: tb/tb_rl_decode_block.sv
// Randomized bench for rl_decode_block against a zigzag/run-length reference model.
module tb_rl_decode_block;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_addr;
  logic [7:0]  out_data;
  logic        block_done;
  logic        err;

  int checks = 0;
  int errors = 0;

  int          zz_order [64];
  logic [14:0] sq [$];

  rl_decode_block dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .block_done (block_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Zigzag order built by walking anti-diagonals, alternating direction.
  task automatic build_zigzag();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_order[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_order[k] = r * 8 + (s - r); k++; end
      end
    end
  endtask

  task automatic send_sym(input logic [14:0] s, output logic err_seen);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = s;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    err_seen = err;
  endtask

  // Sends the symbols in sq through the block terminator and drains the block.
  // mode: 0 always ready, 1 ready one cycle in three, 2 random. abort_at<0 means no reset.
  task automatic run_block(input int mode, input int abort_at);
    logic [7:0] blk [64];
    int   pos = 0;
    int   nsend = sq.size();
    int   err_at = -1;
    int   rd = 0;
    int   cyc = 0;
    logic rdy, e;

    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    for (int k = 0; k < sq.size(); k++) begin
      int run = int'(sq[k][14:8]);
      if (sq[k] == 15'h0) begin nsend = k + 1; break; end
      if (pos + run > 63) begin err_at = k; nsend = k + 1; break; end
      blk[zz_order[pos + run]] = sq[k][7:0];
      pos = pos + run + 1;
      if (pos == 64) begin nsend = k + 1; break; end
    end

    for (int k = 0; k < nsend; k++) begin
      send_sym(sq[k], e);
      check("err_pulse", e, k == err_at);
    end

    while (rd < 64 && cyc < 2000) begin
      if (rd == abort_at) begin
        rst = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_block_done", block_done, 0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 2);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      #1;
      check("out_valid", out_valid, 1);
      check("out_addr", out_addr, rd);
      check("out_data", out_data, blk[rd]);
      check("block_done", block_done, rdy && rd == 63);
      @(negedge clk);
      if (rdy) rd++;
      cyc++;
    end
    out_ready = 1'b0;
    if (rd < 64) check("drain_timeout", rd, 64);
    check("refill_in_ready", in_ready, 1);
    check("refill_out_valid", out_valid, 0);
  endtask

  task automatic gen_random();
    int n = $urandom_range(1, 40);
    sq.delete();
    for (int k = 0; k < n; k++) begin
      logic [6:0] r;
      logic [7:0] v;
      r = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 4));
      v = 8'($urandom_range(0, 255));
      if (r == 0 && v == 0) v = 8'h01;
      sq.push_back({r, v});
    end
    sq.push_back(15'h0);
  endtask

  initial begin
    build_zigzag();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_block_done", block_done, 0);
    check("rst_err", err, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b1;
    @(negedge clk);

    // EOB only -> all-zero block
    sq.delete(); sq.push_back(15'h0);
    run_block(0, -1);

    // Two coefficients then EOB
    sq.delete();
    sq.push_back({7'd0, 8'h05});
    sq.push_back({7'd2, 8'hFD});
    sq.push_back(15'h0);
    run_block(0, -1);

    // Full block, no EOB; then EOB -> zeros
    sq.delete();
    for (int k = 0; k < 64; k++) sq.push_back({7'd0, 8'(k + 1)});
    run_block(0, -1);
    sq.delete(); sq.push_back(15'h0);
    run_block(0, -1);

    // Overflow at pos 60 drops the symbol and drains as-is
    sq.delete();
    for (int k = 0; k < 60; k++) sq.push_back({7'd0, 8'($urandom_range(1, 255))});
    sq.push_back({7'd10, 8'h07});
    run_block(0, -1);

    // Backpressure one-of-three
    gen_random();
    run_block(1, -1);

    // Reset mid-drain, then an all-zero block
    sq.delete();
    for (int k = 0; k < 64; k++) sq.push_back({7'd0, 8'($urandom_range(1, 255))});
    run_block(0, 30);
    sq.delete(); sq.push_back(15'h0);
    run_block(0, -1);

    // Random blocks with random backpressure
    for (int b = 0; b < 20; b++) begin
      gen_random();
      run_block(2, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
